// File: rtl/ysyx_23060187_mem_arbiter.sv
// Two-requester (IFU/LSU) round-robin arbiter in front of a single memory slave port.
// One transaction in flight; a RESP timeout turns a dead slave into an error response.
module ysyx_23060187_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = LSU, 0 = IFU
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic grant_ifu, grant_lsu, owner_rready, timeout_hit;

  // Grants are gated by reset so no ready leaks out while rst is held low.
  assign grant_lsu    = rst && (state_q == IDLE) && lsu_req_valid && !(ifu_req_valid && last_q);
  assign grant_ifu    = rst && (state_q == IDLE) && ifu_req_valid && !grant_lsu;
  assign owner_rready = owner_q ? lsu_resp_ready : ifu_resp_ready;
  assign timeout_hit  = (TIMEOUT != 0) && ((int'(cnt_q) + 1) >= TIMEOUT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (grant_lsu || grant_ifu) begin
          owner_d = grant_lsu;
          addr_d  = grant_lsu ? lsu_addr : ifu_addr;
          wen_d   = grant_lsu && lsu_wen;
          wdata_d = grant_lsu ? lsu_wdata : '0;
          wmask_d = grant_lsu ? lsu_wmask : '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          if (owner_rready) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end else if (timeout_hit) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (owner_rready) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
    endcase
  end

  always_comb begin
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    mem_req_valid  = (state_q == REQ);
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_resp_err   = 1'b0;
    lsu_resp_err   = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    if (state_q == RESP) begin
      mem_resp_ready = owner_rready;
      if (owner_q) begin
        lsu_resp_valid = mem_resp_valid;
        lsu_rdata      = mem_rdata;
      end else begin
        ifu_resp_valid = mem_resp_valid;
        ifu_rdata      = mem_rdata;
      end
    end else if (state_q == ERR) begin
      if (owner_q) begin
        lsu_resp_valid = 1'b1;
        lsu_resp_err   = 1'b1;
      end else begin
        ifu_resp_valid = 1'b1;
        ifu_resp_err   = 1'b1;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Directed and randomized checks of the IFU/LSU memory arbiter against a transaction-level model.
module tb_ysyx_23060187_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 0, ifu_resp_err;
  logic [AW-1:0] ifu_addr = '0;
  logic [DW-1:0] ifu_rdata;
  logic lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 0, lsu_resp_err;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0, lsu_rdata;
  logic [MW-1:0] lsu_wmask = '0;
  logic mem_req_valid, mem_req_ready = 0, mem_wen, mem_resp_valid = 0, mem_resp_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [MW-1:0] mem_wmask;

  int   total = 0;
  int   bad = 0;
  logic last_lsu;
  logic g;

  always #5 clk = ~clk;

  ysyx_23060187_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
                           ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 64'h0);
    check({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'h0);
    check({tag, "_memregs"}, {mem_addr, mem_wen, mem_wmask}, 64'h0);
    check({tag, "_memwdata"}, mem_wdata, 64'h0);
  endtask

  task automatic raise_ifu(input logic [AW-1:0] a);
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
  endtask

  task automatic raise_lsu(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input logic [MW-1:0] m);
    lsu_req_valid = 1'b1;
    lsu_addr      = a;
    lsu_wen       = w;
    lsu_wdata     = d;
    lsu_wmask     = m;
  endtask

  // One full transaction from an IDLE arbiter; the model picks the winner and the expected fields.
  task automatic serve(input int req_wait, input int resp_wait, input int bp,
                       input logic [DW-1:0] rd, output logic got_lsu);
    logic          exp_lsu;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    logic [MW-1:0] em;
    logic [1:0]    one_hot;
    exp_lsu = lsu_req_valid && !(ifu_req_valid && last_lsu);
    if (exp_lsu) begin
      ea = lsu_addr; ew = lsu_wen; ed = lsu_wdata; em = lsu_wmask;
    end else begin
      ea = ifu_addr; ew = 1'b0; ed = '0; em = '0;
    end
    one_hot = exp_lsu ? 2'b01 : 2'b10;
    @(negedge clk);
    check("grant", {ifu_req_ready, lsu_req_ready}, one_hot);
    check("idle_no_req", mem_req_valid, 1'b0);
    got_lsu = lsu_req_ready;
    adv();
    if (exp_lsu) begin
      lsu_req_valid = 1'b0;
      lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wen = ~lsu_wen; lsu_wmask = ~lsu_wmask;
    end else begin
      ifu_req_valid = 1'b0;
      ifu_addr = $urandom;
    end
    for (int i = 0; i <= req_wait; i++) begin
      mem_req_ready = (i == req_wait);
      @(negedge clk);
      check("req_valid", mem_req_valid, 1'b1);
      check("req_fields", {mem_addr, mem_wen, mem_wmask}, {ea, ew, em});
      check("req_wdata", mem_wdata, ed);
      check("req_no_grant", {ifu_req_ready, lsu_req_ready}, 2'b00);
      adv();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      check("resp_wait_valid", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
      adv();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    for (int i = 0; i <= bp; i++) begin
      if (i == bp) begin
        if (exp_lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
      end
      @(negedge clk);
      check("resp_valid", {ifu_resp_valid, lsu_resp_valid}, one_hot);
      check("resp_rdata", {exp_lsu ? lsu_rdata : ifu_rdata, exp_lsu ? ifu_rdata : lsu_rdata},
            {rd, 32'h0});
      check("resp_err", {ifu_resp_err, lsu_resp_err}, 2'b00);
      check("mem_resp_ready", mem_resp_ready, (i == bp));
      check("resp_no_grant", {ifu_req_ready, lsu_req_ready}, 2'b00);
      adv();
    end
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
    last_lsu = exp_lsu;
  endtask

  initial begin
    // Reset with both requesters asserted: nothing may be granted.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1 rst = 1'b0;
    #1 check_quiet("reset");
    last_lsu = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    adv();
    rst = 1'b1;

    // Single IFU read, zero-wait slave.
    raise_ifu(32'h8000_0000);
    serve(0, 0, 0, 32'h0000_0413, g);
    check("ifu_read_owner", g, 1'b0);

    // LSU load with 5 cycles of response backpressure while the IFU waits.
    raise_lsu(32'h8000_2000, 1'b0, 32'h0, 4'h3);
    raise_ifu(32'h8000_0004);
    serve(0, 1, 5, 32'hCAFE_F00D, g);
    check("bp_owner", g, 1'b1);
    serve(1, 0, 0, 32'h0000_0013, g);
    check("bp_next_owner", g, 1'b0);

    // LSU store with mem_req_ready delayed 3 cycles.
    raise_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    serve(3, 2, 0, 32'h0, g);
    check("store_owner", g, 1'b1);

    // Tie after reset: alternating LSU, IFU, LSU, IFU.
    adv();
    rst = 1'b0;
    adv();
    rst = 1'b1;
    last_lsu = 1'b0;
    raise_ifu(32'h8000_0100);
    raise_lsu(32'h8000_3000, 1'b1, 32'h1234_5678, 4'h5);
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, 0, $urandom, g);
      check("tie_seq", g, (i % 2 == 0));
      if (i < 3) begin
        if (g) raise_lsu($urandom, 1'b0, $urandom, 4'hF);
        else   raise_ifu($urandom);
      end
    end
    serve(0, 0, 0, $urandom, g);
    check("tie_tail", g, 1'b1);

    // Timeout: slave never answers.
    raise_ifu(32'h8000_0200);
    @(negedge clk);
    check("to_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    adv();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("to_wait", {ifu_resp_valid, ifu_resp_err}, 2'b00);
      adv();
    end
    @(negedge clk);
    check("to_err", {ifu_resp_valid, ifu_resp_err, mem_resp_ready, lsu_resp_valid}, 4'b1100);
    check("to_rdata", ifu_rdata, 32'h0);
    adv();
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1234;
    @(negedge clk);
    check("to_late", {ifu_resp_valid, ifu_resp_err, mem_resp_ready}, 3'b110);
    check("to_late_rdata", ifu_rdata, 32'h0);
    adv();
    ifu_resp_ready = 1'b1;
    adv();
    ifu_resp_ready = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("to_idle", {ifu_resp_valid, ifu_resp_err, mem_req_valid}, 3'b000);
    adv();
    last_lsu = 1'b0;

    // Reset while in RESP, with a late slave response afterwards.
    raise_ifu(32'h8000_0300);
    adv();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    adv();
    mem_req_ready = 1'b0;
    raise_ifu(32'h8000_0400);
    raise_lsu(32'h8000_4000, 1'b1, 32'hA5A5_A5A5, 4'hC);
    @(negedge clk);
    check("resp_hold_no_grant", {ifu_req_ready, lsu_req_ready, ifu_resp_valid}, 3'b000);
    adv();
    rst = 1'b0;
    #1 check_quiet("mid_reset");
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    adv();
    rst = 1'b1;
    last_lsu = 1'b0;
    #1;
    check("late_resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready, mem_req_valid}, 4'b0000);
    mem_resp_valid = 1'b0;
    serve(0, 0, 0, 32'h0BAD_F00D, g);
    check("post_reset_tie", g, 1'b1);
    serve(0, 0, 0, 32'h0000_0001, g);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!ifu_req_valid && ($urandom_range(1) == 1)) raise_ifu($urandom);
      if (!lsu_req_valid && ($urandom_range(1) == 1))
        raise_lsu($urandom, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)));
      if (!ifu_req_valid && !lsu_req_valid) raise_ifu($urandom);
      serve($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3), $urandom, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060187_mem_arbiter.md
Name: ysyx_23060187_mem_arbiter

Overview:
- Shares the single memory/bus slave port between two requesters: the IFU (instruction fetch, read-only) and the LSU (loads and stores issued from EXU-decoded memory ops).
- One outstanding transaction at a time, round-robin arbitration, and a valid/ready handshake on every channel.
- Sits between the IFU/LSU and the SRAM/bus slave; a response timeout keeps the core from hanging on a dead slave.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; the write mask is DATA_W/8 bits
- TIMEOUT, 1023, maximum cycles spent waiting in RESP; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU can take the response
- ifu_rdata  out  DATA_W  IFU read data
- ifu_resp_err  out  1  IFU response timed out
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte mask
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU can take the response
- lsu_rdata  out  DATA_W  load data
- lsu_resp_err  out  1  LSU response timed out
- mem_req_valid  out  1  request to slave
- mem_req_ready  in  1  slave accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  DATA_W/8  registered byte mask
- mem_resp_valid  in  1  slave response valid
- mem_resp_ready  out  1  arbiter can take the response
- mem_rdata  in  DATA_W  slave read data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=IFU, last_owner=IFU, timeout counter=0.
  - mem_addr, mem_wen, mem_wdata and mem_wmask registers are cleared to 0.
  - All valid, ready and err outputs are 0; both rdata outputs are 0.
- States: IDLE, REQ, RESP, ERR.
- Reset mid-operation: returns to IDLE and discards the in-flight transaction. Any late slave response is not forwarded; the slave is reset alongside.
- IDLE grant rule:
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_owner. After reset the LSU wins the first tie.
  - The granted requester's x_req_ready is asserted combinationally in IDLE only. The other ready stays 0.
- IDLE capture: on the handshake edge, latch owner, addr, wen, wdata and wmask into the mem_* registers, then go to REQ.
  - IFU grants force mem_wen=0 and mem_wmask=0.
- IDLE with no request: stay in IDLE; no outputs asserted.
- REQ: mem_req_valid=1 with the registered fields held stable. On mem_req_ready=1, go to RESP and clear the counter. Never time out in REQ.
- RESP:
  - mem_resp_ready = owner's resp_ready.
  - owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata, combinational pass-through.
  - The non-owner's resp_valid is 0 and its rdata is 0.
  - On mem_resp_valid && owner resp_ready: go to IDLE and set last_owner=owner.
  - The counter increments each RESP cycle without mem_resp_valid. If TIMEOUT≠0 and the counter reaches TIMEOUT, go to ERR.
- ERR:
  - owner's resp_valid=1, resp_err=1, rdata=0; mem_resp_ready=0.
  - On owner resp_ready: go to IDLE and set last_owner=owner.
  - A late slave response after this point is not forwarded.
- Latency: request accepted at cycle 0 → mem_req_valid at cycle 1.
  - With an immediate mem_req_ready and a zero-wait response, the owner sees resp_valid at cycle 2.
  - Minimum back-to-back spacing is 3 cycles. The completion cycle always returns to IDLE before any new grant (one bubble), and requests are never accepted in REQ, RESP or ERR.
- Requesters must hold req_valid and their fields until req_ready. After accepting, the arbiter never uses the requester's live inputs.

Test Plan:
- Single IFU read: ifu_req_valid=1 with addr=0x80000000; slave ready and responds rdata=0x00000413 one cycle later → ifu_req_ready pulses at cycle 0, mem_req_valid at cycle 1 with mem_wen=0, ifu_resp_valid with rdata=0x00000413 at cycle 2; lsu_resp_valid stays 0 throughout.
- LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF; mem_req_ready delayed 3 cycles → mem_req_valid held 4 cycles with the fields unchanged; lsu_resp_valid after the slave response.
- Tie after reset: both requesters valid in the same cycle → LSU granted first, IFU second. With both held valid, grants alternate LSU, IFU, LSU, IFU.
- Response backpressure: lsu_resp_ready=0 for 5 cycles while mem_resp_valid=1 → mem_resp_ready=0 for those cycles, state stays RESP, no new grant.
- Timeout: TIMEOUT=8 and the slave never responds → after 8 RESP cycles, ifu_resp_valid=1 with ifu_resp_err=1 and ifu_rdata=0, then return to IDLE.
- Reset in RESP: rst=0 for one cycle → all valid, ready and err outputs are 0 immediately; state=IDLE; a late mem_resp_valid is not forwarded; the next tie is granted to the LSU.
